// File: rtl/btb_assoc_if.sv
// IF-stage lookup and EX-stage update bus of the set-associative BTB.
interface btb_assoc_if;
    // Lookup side (IF stage)
    logic [31:0] pc_lookup;
    logic        btb_hit;
    logic        btb_predict_taken;
    logic [31:0] btb_target;
    // Maintenance and resolve side (EX stage)
    logic        flush;
    logic        update_en;
    logic [31:0] pc_update;
    logic [31:0] actual_target;
    logic        actual_taken;

    modport master (
        output pc_lookup, flush, update_en, pc_update, actual_target, actual_taken,
        input  btb_hit, btb_predict_taken, btb_target
    );

    modport slave (
        input  pc_lookup, flush, update_en, pc_update, actual_target, actual_taken,
        output btb_hit, btb_predict_taken, btb_target
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: 0-cycle lookup, saturating-counter
// direction prediction, lowest-invalid / round-robin allocation, bulk flush.

// One way of the BTB: SETS entries with a lookup port and an update port.
module btb_assoc_way #(
    parameter int SETS     = 32,
    parameter int IDX      = 5,
    parameter int TAG      = 25,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX-1:0]      rd_idx_i,
    input  logic [TAG-1:0]      rd_tag_i,
    input  logic [IDX-1:0]      up_idx_i,
    input  logic [TAG-1:0]      up_tag_i,
    input  logic                flush_i,
    input  logic                we_i,
    input  logic                alloc_i,
    input  logic                taken_i,
    input  logic [31:0]         target_i,
    output logic                rd_hit_o,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    output logic [31:0]         rd_tgt_o,
    output logic                up_hit_o,
    output logic                up_valid_o
);
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

    logic [SETS-1:0]               valid_q, valid_d;
    logic [SETS-1:0][TAG-1:0]      tag_q,   tag_d;
    logic [SETS-1:0][CTR_BITS-1:0] ctr_q,   ctr_d;
    logic [SETS-1:0][31:0]         tgt_q,   tgt_d;

    assign rd_hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_ctr_o   = ctr_q[rd_idx_i];
    assign rd_tgt_o   = tgt_q[rd_idx_i];
    assign up_hit_o   = valid_q[up_idx_i] && (tag_q[up_idx_i] == up_tag_i);
    assign up_valid_o = valid_q[up_idx_i];

    // Next state: flush wipes valids only; a write either allocates or trains the entry.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        tgt_d   = tgt_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (we_i) begin
            if (alloc_i) begin
                valid_d[up_idx_i] = 1'b1;
                tag_d[up_idx_i]   = up_tag_i;
                tgt_d[up_idx_i]   = target_i;
                ctr_d[up_idx_i]   = CTR_WEAK;
            end else if (taken_i) begin
                tgt_d[up_idx_i] = target_i;
                if (ctr_q[up_idx_i] != CTR_MAX)
                    ctr_d[up_idx_i] = ctr_q[up_idx_i] + 1'b1;
            end else begin
                if (ctr_q[up_idx_i] != '0)
                    ctr_d[up_idx_i] = ctr_q[up_idx_i] - 1'b1;
            end
        end
    end

    // Entry storage; reset clears every field, not just valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            ctr_q   <= '0;
            tgt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
            tgt_q   <= tgt_d;
        end
    end
endmodule

module btb_assoc #(
    parameter int ENTRIES  = 64,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic     clk,
    input  logic     rst,
    btb_assoc_if.slave bus
);
    localparam int SETS  = ENTRIES / WAYS;
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = 30 - IDX;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [IDX-1:0] rd_idx, up_idx;
    logic [TAG-1:0] rd_tag, up_tag;

    assign rd_idx = bus.pc_lookup[IDX+1:2];
    assign rd_tag = bus.pc_lookup[31:IDX+2];
    assign up_idx = bus.pc_update[IDX+1:2];
    assign up_tag = bus.pc_update[31:IDX+2];

    // Byte offset within the word never participates in indexing or tagging.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{bus.pc_lookup[1:0], bus.pc_update[1:0]};

    logic [WAYS-1:0]               rd_hit, up_hit, up_valid, way_we;
    logic [WAYS-1:0][CTR_BITS-1:0] rd_ctr;
    logic [WAYS-1:0][31:0]         rd_tgt;

    logic             upd_go, any_up_hit, alloc;
    logic [WAY_W-1:0] victim, ptr_rd;
    logic             evict_valid;

    // flush wins over a same-cycle update, which is simply dropped.
    assign upd_go     = bus.update_en & ~bus.flush;
    assign any_up_hit = |up_hit;
    assign alloc      = upd_go & ~any_up_hit & bus.actual_taken;

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim      = ptr_rd;
        evict_valid = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!up_valid[w]) begin
                victim      = WAY_W'(w);
                evict_valid = 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_way
            assign way_we[g] = upd_go & (any_up_hit ? up_hit[g]
                                                    : (bus.actual_taken & (victim == WAY_W'(g))));
            btb_assoc_way #(
                .SETS(SETS), .IDX(IDX), .TAG(TAG), .CTR_BITS(CTR_BITS)
            ) u_way (
                .clk        (clk),
                .rst        (rst),
                .rd_idx_i   (rd_idx),
                .rd_tag_i   (rd_tag),
                .up_idx_i   (up_idx),
                .up_tag_i   (up_tag),
                .flush_i    (bus.flush),
                .we_i       (way_we[g]),
                .alloc_i    (~any_up_hit),
                .taken_i    (bus.actual_taken),
                .target_i   (bus.actual_target),
                .rd_hit_o   (rd_hit[g]),
                .rd_ctr_o   (rd_ctr[g]),
                .rd_tgt_o   (rd_tgt[g]),
                .up_hit_o   (up_hit[g]),
                .up_valid_o (up_valid[g])
            );
        end

        if (WAYS > 1) begin : g_ptr
            logic [SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;
            assign ptr_rd = ptr_q[up_idx];

            // Pointer only advances when allocation displaced a live entry.
            always_comb begin
                ptr_d = ptr_q;
                if (bus.flush)
                    ptr_d = '0;
                else if (alloc && evict_valid)
                    ptr_d[up_idx] = ptr_q[up_idx] + 1'b1;
            end

            // Per-set victim pointer register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) ptr_q <= '0;
                else     ptr_q <= ptr_d;
            end
        end else begin : g_noptr
            logic unused_evict;
            assign unused_evict = evict_valid;
            assign ptr_rd       = '0;
        end
    endgenerate

    logic        hit_c, taken_c;
    logic [31:0] tgt_c;

    // Lookup mux; at most one way hits, misses drive all-zero outputs.
    always_comb begin
        hit_c   = 1'b0;
        taken_c = 1'b0;
        tgt_c   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_hit[w]) begin
                hit_c   = 1'b1;
                taken_c = rd_ctr[w][CTR_BITS-1];
                tgt_c   = rd_tgt[w];
            end
        end
    end

    assign bus.btb_hit           = hit_c;
    assign bus.btb_predict_taken = taken_c;
    assign bus.btb_target        = tgt_c;
endmodule
